axi_dma_rd_streamer: RTL and testbench

//  Read-stream engine sitting directly upstream of axi_dma: accepts one command
//  (start address, length in 64-bit words) and splits it into read bursts on the
//  axi_dma request port. Bursts never cross a 1 KB boundary and never exceed cfg_maxburst.

---
 rtl/axi_dma_rd_streamer_pkg.sv | 32 +++
 rtl/axi_dma_rd_streamer_sfifo.sv | 49 ++++
 rtl/axi_dma_rd_streamer.sv | 171 +++++++++++++++++
 tb/tb_axi_dma_rd_streamer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_rd_streamer_pkg.sv
// Shared types for the read streamer: FSM states, control register bundle,
// its reset value and the 1 KB burst boundary.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro used by the top: AXI_DMA_RD_ERR_ABORT_EN.
package axi_dma_rd_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // AXI bursts must not cross a 1 KB address boundary.
  localparam int unsigned BOUNDARY_BYTES = 1024;
  localparam int unsigned BOUNDARY_WORDS = BOUNDARY_BYTES / 8;

  typedef struct packed {
    state_e state;
    logic   error;  // sticky bus-fault flag for the current command
    logic   done;   // single-cycle completion pulse
  } regs_t;

  localparam regs_t REGS_RESET = '{state: IDLE, error: 1'b0, done: 1'b0};

  // Words left before the next 1 KB boundary, given the word index inside
  // the current kilobyte (addr[9:3]). Result is 1..128.
  function automatic logic [7:0] words_to_boundary(input logic [6:0] word_in_kb);
    return 8'(BOUNDARY_WORDS) - {1'b0, word_in_kb};
  endfunction

endpackage

// File: rtl/axi_dma_rd_streamer_sfifo.sv
// Synchronous FIFO, registered storage, head word visible while not empty.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full
//   and no pop when empty. Simultaneous push+pop keeps count unchanged.
// Ports: i_clk, i_nrst (async active-low), push/wdata, pop/rdata, empty, count.
module sfifo #(
  parameter int width      = 65,
  parameter int log2_depth = 6
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  push,
  input  logic [width-1:0]      wdata,
  input  logic                  pop,
  output logic [width-1:0]      rdata,
  output logic                  empty,
  output logic [log2_depth:0]   count
);
  localparam int depth = 2 ** log2_depth;

  logic [width-1:0]      mem [depth];
  logic [log2_depth-1:0] wptr;
  logic [log2_depth-1:0] rptr;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: a flush only needs the pointers cleared.
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/axi_dma_rd_streamer.sv
// Read-stream engine in front of axi_dma: splits one command into bursts
//   (<= maxburst words, never crossing 1 KB), buffers read data, streams it out.
// Latency: command accept -> o_req_mem_valid 1 cycle; response -> o_str_valid 1 cycle.
// Backpressure: a burst is requested only when the FIFO has room for all of
//   it, so responses are always accepted; i_str_ready stalls only the FIFO.
// Optional: AXI_DMA_RD_ERR_ABORT_EN -- on a faulting word, stop after the
//   current burst and mark its final beat as the stream's last word.
// Ports: i_cmd_* command in; o_req_mem_*/i_req_mem_ready burst request to
//   axi_dma; i_resp_mem_*/o_resp_mem_ready read data from axi_dma;
//   o_str_*/i_str_ready output stream; o_busy/o_done/o_error status.
module axi_dma_rd_streamer
  import axi_dma_rd_streamer_pkg::*;
#(
  parameter int abits      = 48,
  parameter int log2_depth = 6,
  parameter int maxburst   = 32,
  parameter int lenbits    = 16
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [abits-1:0]   i_cmd_addr,
  input  logic [lenbits-1:0] i_cmd_len,
  output logic               o_req_mem_valid,
  input  logic               i_req_mem_ready,
  output logic               o_req_mem_write,
  output logic [9:0]         o_req_mem_bytes,
  output logic [abits-1:0]   o_req_mem_addr,
  output logic [7:0]         o_req_mem_strob,
  output logic [63:0]        o_req_mem_data,
  output logic               o_req_mem_last,
  input  logic               i_resp_mem_valid,
  input  logic               i_resp_mem_last,
  input  logic               i_resp_mem_fault,
  input  logic [63:0]        i_resp_mem_data,
  output logic               o_resp_mem_ready,
  output logic               o_str_valid,
  output logic [63:0]        o_str_data,
  output logic               o_str_last,
  input  logic               i_str_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);
  localparam int            CW    = log2_depth + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** log2_depth);
  localparam logic [7:0]    MAXB  = 8'(maxburst);

  regs_t               r, rin;
  logic [abits-1:0]    addr, addr_nxt;
  logic [lenbits-1:0]  remaining, remaining_nxt;
  logic [CW-1:0]       reserved, reserved_nxt;

  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [64:0]         fifo_head;
  logic                push, push_last, pop;
  logic [7:0]          burst_words;
  logic                space_ok;

  // Burst size: limited by remaining length, maxburst and the 1 KB boundary.
  always_comb begin
    burst_words = words_to_boundary(addr[9:3]);
    if (MAXB < burst_words) burst_words = MAXB;
    if (remaining < lenbits'(burst_words)) burst_words = 8'(remaining);
  end

  // Space already promised to an outstanding burst counts as used, which is
  // what lets o_resp_mem_ready stay high.
  assign space_ok = 32'(DEPTH - fifo_count - reserved) >= 32'(burst_words);
  assign pop      = !fifo_empty && i_str_ready;

  always_comb begin
    rin           = r;
    rin.done      = 1'b0;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    reserved_nxt  = reserved;
    push          = 1'b0;
    push_last     = 1'b0;
    case (r.state)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_nxt      = i_cmd_addr & ~abits'(7);
          remaining_nxt = i_cmd_len;
          rin.error     = 1'b0;
          if (i_cmd_len == '0) rin.done  = 1'b1;
          else                 rin.state = REQ;
        end
      end
      REQ: begin
        // space_ok only grows while waiting (pops only), so valid never drops
        // before the handshake and addr/bytes stay stable.
        if (space_ok && i_req_mem_ready) begin
          reserved_nxt  = reserved + CW'(burst_words);
          addr_nxt      = addr + abits'({burst_words, 3'b000});
          remaining_nxt = remaining - lenbits'(burst_words);
          rin.state     = RESP;
        end
      end
      RESP: begin
        if (i_resp_mem_valid) begin
          push         = 1'b1;
          reserved_nxt = reserved - CW'(1);
          if (i_resp_mem_fault) rin.error = 1'b1;
`ifdef AXI_DMA_RD_ERR_ABORT_EN
          if (i_resp_mem_fault) remaining_nxt = '0;
`endif
          // Uses the post-fault remaining so an abort on the final beat
          // still tags that beat as the stream's last word.
          push_last = (remaining_nxt == '0) && i_resp_mem_last;
          if (i_resp_mem_last) rin.state = (remaining_nxt != '0) ? REQ : DRAIN;
        end
      end
      DRAIN: begin
        // The last-tagged word is the final one pushed, so its pop empties the FIFO.
        if (pop && fifo_head[64]) begin
          rin.done  = 1'b1;
          rin.state = IDLE;
        end
      end
      default: rin = REGS_RESET;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r         <= REGS_RESET;
      addr      <= '0;
      remaining <= '0;
      reserved  <= '0;
    end else begin
      r         <= rin;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      reserved  <= reserved_nxt;
    end
  end

  sfifo #(
    .width      (65),
    .log2_depth (log2_depth)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .push   (push),
    .wdata  ({push_last, i_resp_mem_data}),
    .pop    (pop),
    .rdata  (fifo_head),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign o_cmd_ready      = (r.state == IDLE);
  assign o_req_mem_valid  = (r.state == REQ) && space_ok;
  assign o_req_mem_write  = 1'b0;
  assign o_req_mem_bytes  = {burst_words[6:0], 3'b000};
  assign o_req_mem_addr   = addr;
  assign o_req_mem_strob  = 8'h00;
  assign o_req_mem_data   = 64'h0;
  assign o_req_mem_last   = 1'b1;
  assign o_resp_mem_ready = 1'b1;
  assign o_str_valid      = !fifo_empty;
  assign o_str_data       = fifo_empty ? 64'h0 : fifo_head[63:0];
  assign o_str_last       = !fifo_empty && fifo_head[64];
  assign o_busy           = (r.state != IDLE) || !fifo_empty;
  assign o_done           = r.done;
  assign o_error          = r.error;

endmodule

// File: tb/tb_axi_dma_rd_streamer.sv
// Bench for axi_dma_rd_streamer: two instances (depth 64/maxburst 32 and
// depth 128/maxburst 128), a randomised single-outstanding memory responder,
// and a burst/stream reference model derived from address arithmetic.
`timescale 1ns/1ps
module tb_axi_dma_rd_streamer;
`ifdef AXI_DMA_RD_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        cmd_valid[2], cmd_ready[2];
  logic [47:0] cmd_addr[2];
  logic [15:0] cmd_len[2];
  logic        req_valid[2], req_ready[2], req_write[2], req_last[2];
  logic [9:0]  req_bytes[2];
  logic [47:0] req_addr[2];
  logic [7:0]  req_strob[2];
  logic [63:0] req_data[2];
  logic        resp_valid[2], resp_last[2], resp_fault[2], resp_ready[2];
  logic [63:0] resp_data[2];
  logic        str_valid[2], str_last[2], str_ready[2];
  logic [63:0] str_data[2];
  logic        busy[2], done[2], error_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_dma_rd_streamer #(
      .abits(48), .log2_depth(g == 0 ? 6 : 7), .maxburst(g == 0 ? 32 : 128), .lenbits(16)
    ) dut (
      .i_clk(clk), .i_nrst(nrst),
      .i_cmd_valid(cmd_valid[g]), .o_cmd_ready(cmd_ready[g]),
      .i_cmd_addr(cmd_addr[g]), .i_cmd_len(cmd_len[g]),
      .o_req_mem_valid(req_valid[g]), .i_req_mem_ready(req_ready[g]),
      .o_req_mem_write(req_write[g]), .o_req_mem_bytes(req_bytes[g]),
      .o_req_mem_addr(req_addr[g]), .o_req_mem_strob(req_strob[g]),
      .o_req_mem_data(req_data[g]), .o_req_mem_last(req_last[g]),
      .i_resp_mem_valid(resp_valid[g]), .i_resp_mem_last(resp_last[g]),
      .i_resp_mem_fault(resp_fault[g]), .i_resp_mem_data(resp_data[g]),
      .o_resp_mem_ready(resp_ready[g]),
      .o_str_valid(str_valid[g]), .o_str_data(str_data[g]), .o_str_last(str_last[g]),
      .i_str_ready(str_ready[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_error(error_o[g])
    );
  end

  // Environment state
  int          act = 0;
  bit          hold_rdy = 1'b0;
  int          rsp_rem[2], beat_cnt[2], fault_at[2];
  logic [47:0] rsp_addr[2];
  logic [31:0] seed[2];
  int          buffered, maxbuf, done_cnt;
  logic [47:0] rq_addr[$];
  int          rq_words[$];
  logic [63:0] st_data[$];
  bit          st_last[$];
  logic [47:0] ex_addr[$];
  int          ex_words[$];

  function automatic logic [63:0] mem_word(input logic [47:0] a, input logic [31:0] s);
    return {a[31:0] ^ s, a[47:16] + s};
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 64 : 128;
  endfunction

  // Reference burst list: each burst is min(remaining, maxburst, words to 1 KB).
  function automatic int build_expected(input logic [47:0] addr, input int len,
                                        input int mb, input int fidx);
    logic [47:0] a;
    int rem, start, n;
    ex_addr.delete();
    ex_words.delete();
    a = addr & ~48'h7;
    rem = len;
    start = 0;
    while (rem > 0) begin
      n = 128 - int'(a[9:3]);
      if (n > mb) n = mb;
      if (n > rem) n = rem;
      ex_addr.push_back(a);
      ex_words.push_back(n);
      if (ABORT && fidx >= start && fidx < start + n) rem = 0;
      else rem -= n;
      start += n;
      a = a + 48'(8 * n);
    end
    return start;
  endfunction

  // Memory responder: one burst at a time, random beat gaps and ready delays.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < 2; k++) begin
        rsp_rem[k]    = 0;
        req_ready[k]  <= 1'b0;
        resp_valid[k] <= 1'b0;
        resp_last[k]  <= 1'b0;
        resp_fault[k] <= 1'b0;
        resp_data[k]  <= 64'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          rsp_rem[k]  = (req_bytes[k] == 10'd0) ? 128 : int'(req_bytes[k]) / 8;
          rsp_addr[k] = req_addr[k];
        end
        if (rsp_rem[k] > 0 && ($urandom % 3) != 0) begin
          resp_valid[k] <= 1'b1;
          resp_data[k]  <= mem_word(rsp_addr[k], seed[k]);
          resp_last[k]  <= (rsp_rem[k] == 1);
          resp_fault[k] <= (beat_cnt[k] == fault_at[k]);
          beat_cnt[k]   = beat_cnt[k] + 1;
          rsp_addr[k]   = rsp_addr[k] + 48'd8;
          rsp_rem[k]    = rsp_rem[k] - 1;
        end else begin
          resp_valid[k] <= 1'b0;
          resp_last[k]  <= 1'b0;
          resp_fault[k] <= 1'b0;
        end
        req_ready[k] <= (rsp_rem[k] == 0) && (($urandom % 3) != 0);
      end
    end
  end

  // Consumer ready driver and monitor for the active instance.
  always @(negedge clk) begin
    int n;
    for (int k = 0; k < 2; k++)
      str_ready[k] = (k != act) ? 1'b1 : (hold_rdy ? 1'b0 : (($urandom % 4) != 0));
    if (nrst) begin
      if (req_valid[act] && req_ready[act]) begin
        n = (req_bytes[act] == 10'd0) ? 128 : int'(req_bytes[act]) / 8;
        n_checks++;
        if (buffered + n > depth_of(act)) begin
          n_fail++;
          $display("FAIL space_at_req: buffered+burst=%0d, required <= %0d", buffered + n, depth_of(act));
        end
        rq_addr.push_back(req_addr[act]);
        rq_words.push_back(n);
      end
      if (resp_valid[act] && resp_ready[act]) buffered++;
      if (str_valid[act] && str_ready[act]) begin
        buffered--;
        st_data.push_back(str_data[act]);
        st_last.push_back(str_last[act]);
      end
      if (buffered > maxbuf) maxbuf = buffered;
      if (done[act]) done_cnt++;
    end
  end

  task automatic run_cmd(input int k, input logic [47:0] addr, input int len,
                         input int fidx, input int hold, input string name);
    int depth, total, budget, pre_reqs, pre_words;
    logic [47:0] a0;
    bit exp_err;
    depth = depth_of(k);
    total = build_expected(addr, len, (k == 0) ? 32 : 128, fidx);
    exp_err = (fidx >= 0) && (fidx < total);
    a0 = addr & ~48'h7;
    act = k;
    rq_addr.delete(); rq_words.delete(); st_data.delete(); st_last.delete();
    buffered = 0; maxbuf = 0; done_cnt = 0;
    fault_at[k] = fidx; beat_cnt[k] = 0; seed[k] = $urandom;
    hold_rdy = (hold > 0);

    budget = 0;
    @(negedge clk);
    while (!cmd_ready[k] && budget < 1000) begin @(negedge clk); budget++; end
    n_checks++;
    if (cmd_ready[k] !== 1'b1) begin
      n_fail++; $display("FAIL %s_cmd_ready: got %b, required 1", name, cmd_ready[k]);
    end
    cmd_valid[k] = 1'b1; cmd_addr[k] = addr; cmd_len[k] = 16'(len);
    @(posedge clk); #1 cmd_valid[k] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (len == 0) begin
      if (done[k] !== 1'b1) begin
        n_fail++; $display("FAIL %s_done_latency: o_done=%b, required 1", name, done[k]);
      end
    end else if (req_valid[k] !== 1'b1) begin
      n_fail++; $display("FAIL %s_req_latency: o_req_mem_valid=%b, required 1", name, req_valid[k]);
    end

    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      pre_reqs = 0; pre_words = 0;
      foreach (ex_words[i]) begin
        if (pre_words + ex_words[i] > depth) break;
        pre_words += ex_words[i]; pre_reqs++;
      end
      n_checks++;
      if (rq_addr.size() != pre_reqs) begin
        n_fail++; $display("FAIL %s_held_reqs: got %0d, required %0d", name, rq_addr.size(), pre_reqs);
      end
      n_checks++;
      if (buffered != pre_words || st_data.size() != 0) begin
        n_fail++; $display("FAIL %s_held_buffered: got %0d words (%0d popped), required %0d (0)",
                           name, buffered, st_data.size(), pre_words);
      end
      n_checks++;
      if (cmd_ready[k] !== 1'b0) begin
        n_fail++; $display("FAIL %s_busy_cmd_ready: got %b, required 0", name, cmd_ready[k]);
      end
      // A command offered while busy must be ignored.
      cmd_valid[k] = 1'b1; cmd_addr[k] = 48'hABC008; cmd_len[k] = 16'd5;
      @(posedge clk); #1 cmd_valid[k] = 1'b0;
      hold_rdy = 1'b0;
    end

    budget = 0;
    while (done_cnt == 0 && budget < 20000) begin @(negedge clk); budget++; end
    repeat (5) @(negedge clk);

    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_cnt);
    end
    n_checks++;
    if (busy[k] !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_after: got %b, required 0", name, busy[k]);
    end
    n_checks++;
    if (rq_addr.size() != ex_addr.size()) begin
      n_fail++; $display("FAIL %s_req_count: got %0d, required %0d", name, rq_addr.size(), ex_addr.size());
    end
    for (int i = 0; i < rq_addr.size() && i < ex_addr.size(); i++) begin
      n_checks++;
      if (rq_addr[i] !== ex_addr[i] || rq_words[i] != ex_words[i]) begin
        n_fail++; $display("FAIL %s_req%0d: got %0d words @%0h, required %0d @%0h",
                           name, i, rq_words[i], rq_addr[i], ex_words[i], ex_addr[i]);
      end
    end
    n_checks++;
    if (st_data.size() != total) begin
      n_fail++; $display("FAIL %s_word_count: got %0d, required %0d", name, st_data.size(), total);
    end
    for (int i = 0; i < st_data.size() && i < total; i++) begin
      n_checks++;
      if (st_data[i] !== mem_word(a0 + 48'(8 * i), seed[k]) || st_last[i] != (i == total - 1)) begin
        n_fail++; $display("FAIL %s_word%0d: got %h last=%b, required %h last=%b", name, i,
                           st_data[i], st_last[i], mem_word(a0 + 48'(8 * i), seed[k]), (i == total - 1));
      end
    end
    n_checks++;
    if (error_o[k] !== exp_err) begin
      n_fail++; $display("FAIL %s_error: got %b, required %b", name, error_o[k], exp_err);
    end
    n_checks++;
    if (maxbuf > depth) begin
      n_fail++; $display("FAIL %s_overflow: peak %0d words, required <= %0d", name, maxbuf, depth);
    end
    fault_at[k] = -1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs = {cmd_ready[k], resp_ready[k], req_valid[k], str_valid[k], busy[k],
             done[k], error_o[k], req_write[k], req_last[k], str_last[k]};
      n_checks++;
      if (obs !== 10'b11_0000_0010) begin
        n_fail++; $display("FAIL reset_outputs%0d: got %b, required 1100000010", k, obs);
      end
      n_checks++;
      if (req_strob[k] !== 8'h0 || req_data[k] !== 64'h0 || str_data[k] !== 64'h0) begin
        n_fail++; $display("FAIL reset_buses%0d: strob=%h data=%h str=%h, required zeros",
                           k, req_strob[k], req_data[k], str_data[k]);
      end
    end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    run_cmd(0, 48'h1000, 4, -1, 0, "single");
  endtask

  task automatic test_boundary_split();
    run_cmd(0, 48'h13E0, 40, -1, 0, "boundary");
  endtask

  task automatic test_max_burst();
    run_cmd(1, 48'h0, 128, -1, 0, "maxburst128");
  endtask

  task automatic test_backpressure();
    run_cmd(0, 48'h2000, 100, -1, 300, "hold");
  endtask

  task automatic test_fault();
    run_cmd(0, 48'h4000, 64, 2, 0, "fault");
  endtask

  task automatic test_zero_len();
    run_cmd(0, 48'h5000, 0, -1, 0, "zerolen");
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] obs;
    act = 0; hold_rdy = 1'b1; fault_at[0] = -1; beat_cnt[0] = 0; seed[0] = $urandom;
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_addr[0] = 48'h8000; cmd_len[0] = 16'd100;
    @(posedge clk); #1 cmd_valid[0] = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++;
    if (str_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_precond: o_str_valid=%b, required 1", str_valid[0]);
    end
    nrst = 1'b0;
    @(negedge clk);
    obs = {cmd_ready[0], str_valid[0], busy[0], req_valid[0]};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++; $display("FAIL midreset_state: got %b, required 1000", obs);
    end
    nrst = 1'b1;
    hold_rdy = 1'b0;
    @(negedge clk);
    run_cmd(0, 48'h9000, 10, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int k, len, f;
      logic [47:0] a;
      k   = int'($urandom % 2);
      a   = {16'h0, $urandom()};
      len = 1 + int'($urandom % 300);
      f   = (($urandom % 3) == 0) ? int'($urandom % len) : -1;
      run_cmd(k, a, len, f, 0, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_addr[k] = '0; cmd_len[k] = '0;
      fault_at[k] = -1; beat_cnt[k] = 0; seed[k] = '0;
    end
    test_reset();
    test_single_burst();
    test_boundary_split();
    test_max_burst();
    test_backpressure();
    test_fault();
    test_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

endmodule
